// File: rtl/ctrl_pkg.sv
// Shared opcode, state and field definitions for the 18-bit processor control unit.
package ctrl_pkg;

    typedef logic [3:0] opcode_t;

    localparam int OPC_W = 4;

    // 0100/0101 are the immediate forms of ADD/AND (ALU operand B = imm).
    localparam opcode_t OP_ADD     = 4'b0000;
    localparam opcode_t OP_AND     = 4'b0001;
    localparam opcode_t OP_NAND    = 4'b0010;
    localparam opcode_t OP_NOR     = 4'b0011;
    localparam opcode_t OP_ADDI    = 4'b0100;
    localparam opcode_t OP_ANDI    = 4'b0101;
    localparam opcode_t OP_LD      = 4'b0110;
    localparam opcode_t OP_ST      = 4'b0111;
    localparam opcode_t OP_JMP     = 4'b1000;
    localparam opcode_t OP_CMP     = 4'b1001;
    localparam opcode_t OP_JE      = 4'b1010;
    localparam opcode_t OP_JA      = 4'b1011;
    localparam opcode_t OP_JB      = 4'b1100;
    localparam opcode_t OP_JAE     = 4'b1101;
    localparam opcode_t OP_JBE     = 4'b1110;
    localparam opcode_t OP_ILLEGAL = 4'b1111;

    localparam logic [2:0] FETCH   = 3'd0;
    localparam logic [2:0] DECODE  = 3'd1;
    localparam logic [2:0] EXECUTE = 3'd2;
    localparam logic [2:0] MEM     = 3'd3;
    localparam logic [2:0] WB      = 3'd4;
    localparam logic [2:0] TRAP    = 3'd5;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;
    localparam logic [1:0] ALU_NOR  = 2'b11;

    localparam int DST_LSB      = 10;
    localparam int SRC1_LSB     = 6;
    localparam int SRC2_LSB     = 0;
    localparam int IMM_LSB      = 0;
    localparam int MEM_ADDR_LSB = 0;
    localparam int JUMP_LSB     = 0;

    function automatic logic [1:0] alu_code(input opcode_t op);
        case (op)
            OP_AND, OP_ANDI: alu_code = ALU_AND;
            OP_NAND:         alu_code = ALU_NAND;
            OP_NOR:          alu_code = ALU_NOR;
            default:         alu_code = ALU_ADD;
        endcase
    endfunction

    function automatic logic is_alu_op(input opcode_t op);
        is_alu_op = (op <= OP_ANDI);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Decides whether the current jump is taken, from the opcode and the latched CMP flags.
module branch_resolve
    import ctrl_pkg::*;
(
    input  opcode_t    opcode,
    input  logic [2:0] flags,
    output logic       taken
);

    logic below;
    logic equal;
    logic above;

    assign {below, equal, above} = flags;

    always_comb begin
        case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_JE:   taken = equal;
            OP_JA:   taken = above;
            OP_JB:   taken = below;
            OP_JAE:  taken = above | equal;
            OP_JBE:  taken = below | equal;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with latched CMP flags and illegal-opcode trap.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int INSTR_W    = 18,
    parameter int REG_ADDR_W = 4,
    parameter int IMM_W      = 6,
    parameter int MEM_ADDR_W = 10,
    parameter int JUMP_W     = 14,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_W-1:0]    instr_data,
    input  logic                  instr_valid,
    input  logic                  mem_ready,
    input  logic                  below,
    input  logic                  equal,
    input  logic                  above,
    output logic                  fetch_req,
    output logic                  pc_write,
    output logic                  pc_sel_jump,
    output logic [JUMP_W-1:0]     jump_addr,
    output logic                  is_imm,
    output logic [IMM_W-1:0]      imm,
    output logic [1:0]            alu_ctrl,
    output logic [REG_ADDR_W-1:0] src1,
    output logic [REG_ADDR_W-1:0] src2,
    output logic [REG_ADDR_W-1:0] dst,
    output logic                  reg_write_en,
    output logic                  mem_to_reg,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [2:0]            flags_q,
    output logic                  illegal,
    output logic [CNT_W-1:0]      retired
);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [INSTR_W-1:0] ir;
    opcode_t            op;
    logic               taken;

    assign op = ir[INSTR_W-1 -: OPC_W];

    branch_resolve u_branch_resolve (
        .opcode (op),
        .flags  (flags_q),
        .taken  (taken)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (instr_valid) state_nxt = DECODE;
            DECODE: begin
                if (op == OP_ILLEGAL)                 state_nxt = TRAP;
                else if (op == OP_LD || op == OP_ST)  state_nxt = MEM;
                else                                  state_nxt = EXECUTE;
            end
            EXECUTE: state_nxt = is_alu_op(op) ? WB : FETCH;
            MEM:     if (mem_ready) state_nxt = (op == OP_LD) ? WB : FETCH;
            WB:      state_nxt = FETCH;
            TRAP:    state_nxt = TRAP;
            default: state_nxt = FETCH;
        endcase
    end

    // Strobes are masked during reset so an aborted instruction never writes or retires.
    always_comb begin
        fetch_req    = 1'b0;
        pc_write     = 1'b0;
        pc_sel_jump  = 1'b0;
        reg_write_en = 1'b0;
        mem_to_reg   = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: fetch_req = 1'b1;
                EXECUTE: begin
                    if (!is_alu_op(op)) begin
                        pc_write    = 1'b1;
                        pc_sel_jump = taken;
                    end
                end
                MEM: begin
                    if (op == OP_LD) begin
                        mem_read_en = 1'b1;
                    end else begin
                        mem_write_en = 1'b1;
                        pc_write     = mem_ready;
                    end
                end
                WB: begin
                    reg_write_en = 1'b1;
                    mem_to_reg   = (op == OP_LD);
                    pc_write     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            ir        <= '0;
            jump_addr <= '0;
            is_imm    <= 1'b0;
            imm       <= '0;
            alu_ctrl  <= ALU_ADD;
            src1      <= '0;
            src2      <= '0;
            dst       <= '0;
            mem_addr  <= '0;
            flags_q   <= '0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && instr_valid) begin
                ir <= instr_data;
            end
            if (state == DECODE) begin
                jump_addr <= ir[JUMP_LSB +: JUMP_W];
                is_imm    <= (op == OP_ADDI) || (op == OP_ANDI);
                imm       <= ir[IMM_LSB +: IMM_W];
                alu_ctrl  <= alu_code(op);
                src1      <= ir[SRC1_LSB +: REG_ADDR_W];
                src2      <= ir[SRC2_LSB +: REG_ADDR_W];
                dst       <= ir[DST_LSB +: REG_ADDR_W];
                mem_addr  <= ir[MEM_ADDR_LSB +: MEM_ADDR_W];
                if (op == OP_ILLEGAL) begin
                    illegal <= 1'b1;
                end
            end
            if (state == EXECUTE && op == OP_CMP) begin
                flags_q <= {below, equal, above};
            end
            if (pc_write) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule
